// File: rtl/alu_ctrl_mc.sv
// ALU control decode with a multi-cycle mult/div sequencer.
// Define ALU_CTRL_MDU_EN to build the MUL/DIV decode and the BUSY sequencer.
//
// state | meaning
// IDLE  | ready for a new instruction; single-cycle ops complete here
// BUSY  | MDU op in flight; cnt counts down to the completion edge
module alu_ctrl_mc #(
  parameter int CTRL_W    = 4,
  parameter int MC_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              valid_o,
  output logic              illegal_o,
  output logic              mdu_start_o,
  output logic              mdu_op_o
);

  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_SLT = 4'b0111;

  if (CTRL_W < 4 || MC_CYCLES < 1) begin : g_param_check
    $error("alu_ctrl_mc: CTRL_W must be >= 4 and MC_CYCLES >= 1");
  end

  logic [3:0] dec_code;
  logic       dec_ill;
`ifdef ALU_CTRL_MDU_EN
  localparam logic [3:0] C_MUL = 4'b1000;
  localparam logic [3:0] C_DIV = 4'b1001;
  logic dec_mdu;
  logic dec_div;
`endif

  always_comb begin
    dec_code = C_ADD;
    dec_ill  = 1'b0;
`ifdef ALU_CTRL_MDU_EN
    dec_mdu  = 1'b0;
    dec_div  = 1'b0;
`endif
    case (ALUOp_i)
      2'b00: dec_code = C_ADD;
      2'b01: dec_code = C_SUB;
      2'b11: dec_code = C_OR;
      default: begin
        case (funct_i)
          6'b100011: dec_code = C_ADD;
          6'b100001: dec_code = C_SUB;
          6'b100110: dec_code = C_AND;
          6'b100101: dec_code = C_OR;
          6'b101011: dec_code = C_NOR;
          6'b101000: dec_code = C_SLT;
`ifdef ALU_CTRL_MDU_EN
          6'b011000: dec_mdu = 1'b1;
          6'b011010: begin
            dec_mdu = 1'b1;
            dec_div = 1'b1;
          end
`endif
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
  end

`ifdef ALU_CTRL_MDU_EN
  localparam int CNT_W = $clog2(MC_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign ready_o = (state == IDLE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      ALUCtrl_o   <= CTRL_W'(C_ADD);
      valid_o     <= 1'b0;
      illegal_o   <= 1'b0;
      mdu_start_o <= 1'b0;
      mdu_op_o    <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      illegal_o   <= 1'b0;
      mdu_start_o <= 1'b0;
      if (flush_i) begin
        // Abort whatever is in flight; the last code and MDU op stay visible.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (valid_i) begin
              if (dec_mdu) begin
                state       <= BUSY;
                cnt         <= CNT_W'(MC_CYCLES - 1);
                mdu_op_o    <= dec_div;
                mdu_start_o <= 1'b1;
              end else begin
                ALUCtrl_o <= CTRL_W'(dec_code);
                valid_o   <= 1'b1;
                illegal_o <= dec_ill;
              end
            end
          end
          BUSY: begin
            if (cnt == '0) begin
              state     <= IDLE;
              ALUCtrl_o <= CTRL_W'(mdu_op_o ? C_DIV : C_MUL);
              valid_o   <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`else
  assign ready_o     = 1'b1;
  assign mdu_start_o = 1'b0;
  assign mdu_op_o    = 1'b0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ALUCtrl_o <= CTRL_W'(C_ADD);
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
      if (valid_i && !flush_i) begin
        ALUCtrl_o <= CTRL_W'(dec_code);
        valid_o   <= 1'b1;
        illegal_o <= dec_ill;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: directed decode cases, randomized
// single-cycle traffic against a table-driven model, and MDU sequencing.
module tb_alu_ctrl_mc;
  localparam int CTRL_W = 4;
  localparam int MC     = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              valid_i = 1'b0;
  logic              flush_i = 1'b0;
  logic [1:0]        ALUOp_i = 2'b00;
  logic [5:0]        funct_i = 6'b0;
  logic              ready_o;
  logic [CTRL_W-1:0] ALUCtrl_o;
  logic              valid_o;
  logic              illegal_o;
  logic              mdu_start_o;
  logic              mdu_op_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  alu_ctrl_mc #(.CTRL_W(CTRL_W), .MC_CYCLES(MC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .flush_i(flush_i),
    .ALUCtrl_o(ALUCtrl_o), .valid_o(valid_o), .illegal_o(illegal_o),
    .mdu_start_o(mdu_start_o), .mdu_op_o(mdu_op_o)
  );

  // funct -> code table; the last two entries exist only with the MDU built in
  logic [5:0] fn_tab [8] = '{6'b100011, 6'b100001, 6'b100110, 6'b100101,
                             6'b101011, 6'b101000, 6'b011000, 6'b011010};
  logic [3:0] cd_tab [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                             4'b1100, 4'b0111, 4'b1000, 4'b1001};
`ifdef ALU_CTRL_MDU_EN
  localparam int N_FN = 8;
`else
  localparam int N_FN = 6;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output logic [3:0] code, output logic ill,
                                     output logic mdu);
    code = 4'b0010;
    ill  = 1'b0;
    mdu  = 1'b0;
    if (op == 2'b01) code = 4'b0110;
    else if (op == 2'b11) code = 4'b0001;
    else if (op == 2'b10) begin
      ill = 1'b1;
      for (int i = 0; i < N_FN; i++)
        if (fn_tab[i] == f) begin
          code = cd_tab[i];
          ill  = 1'b0;
          mdu  = (i >= 6);
        end
    end
  endfunction

  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic v, input logic fl);
    ALUOp_i = op;
    funct_i = f;
    valid_i = v;
    flush_i = fl;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_code"}, 32'(ALUCtrl_o), 32'h2);
    chk({tag, "_valid"}, 32'(valid_o), 0);
    chk({tag, "_illegal"}, 32'(illegal_o), 0);
    chk({tag, "_ready"}, 32'(ready_o), 1);
    chk({tag, "_start"}, 32'(mdu_start_o), 0);
    chk({tag, "_mdu_op"}, 32'(mdu_op_o), 0);
  endtask

  logic [3:0] e_code, held_code;
  logic       e_ill, e_mdu, e_valid;
  logic [1:0] r_op;
  logic [5:0] r_f;
  logic       r_v, r_fl;
  logic [1:0] op_tab [3] = '{2'b00, 2'b01, 2'b11};
  logic [3:0] op_code [3] = '{4'b0010, 4'b0110, 4'b0001};

  initial begin
    #12;
    chk_reset_vals("reset");
    rst_i = 1'b1;

    for (int i = 0; i < 6; i++) begin
      drive(2'b10, fn_tab[i], 1'b1, 1'b0);
      step();
      chk($sformatf("rtype%0d_code", i), 32'(ALUCtrl_o), 32'(cd_tab[i]));
      chk($sformatf("rtype%0d_valid", i), 32'(valid_o), 1);
      chk($sformatf("rtype%0d_illegal", i), 32'(illegal_o), 0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(op_tab[i], 6'b000000, 1'b1, 1'b0);
      step();
      chk($sformatf("aluop%0d_code", op_tab[i]), 32'(ALUCtrl_o), 32'(op_code[i]));
      chk($sformatf("aluop%0d_valid", op_tab[i]), 32'(valid_o), 1);
    end
    drive(2'b10, 6'b111111, 1'b1, 1'b0);
    step();
    chk("bad_funct_code", 32'(ALUCtrl_o), 32'h2);
    chk("bad_funct_illegal", 32'(illegal_o), 1);
    chk("bad_funct_valid", 32'(valid_o), 1);
    held_code = 4'b0010;

    // Random single-cycle traffic with idle cycles and flushes
    for (int n = 0; n < 300; n++) begin
      r_op = 2'($urandom);
      r_f  = ($urandom_range(0, 1) == 0) ? fn_tab[$urandom_range(0, 7)] : 6'($urandom);
      r_v  = ($urandom_range(0, 3) != 0);
      r_fl = ($urandom_range(0, 7) == 0);
      ref_decode(r_op, r_f, e_code, e_ill, e_mdu);
      if (e_mdu) begin
        r_f = 6'b100011;
        ref_decode(r_op, r_f, e_code, e_ill, e_mdu);
      end
      drive(r_op, r_f, r_v, r_fl);
      step();
      e_valid = r_v && !r_fl;
      if (e_valid) held_code = e_code;
      chk("rand_valid", 32'(valid_o), 32'(e_valid));
      chk("rand_code", 32'(ALUCtrl_o), 32'(held_code));
      chk("rand_illegal", 32'(illegal_o), 32'(e_valid && e_ill));
      chk("rand_ready", 32'(ready_o), 1);
    end
    drive(2'b00, 6'b0, 1'b0, 1'b0);
    step();

`ifdef ALU_CTRL_MDU_EN
    // mult: busy MC cycles, then MUL code; a held add follows one cycle later
    drive(2'b10, 6'b011000, 1'b1, 1'b0);
    step();
    chk("mul_start", 32'(mdu_start_o), 1);
    chk("mul_op", 32'(mdu_op_o), 0);
    chk("mul_valid_t0", 32'(valid_o), 0);
    chk("mul_ready_t0", 32'(ready_o), 0);
    drive(2'b00, 6'b0, 1'b1, 1'b0);
    for (int k = 1; k < MC; k++) begin
      step();
      chk($sformatf("mul_ready_t%0d", k), 32'(ready_o), 0);
      chk($sformatf("mul_valid_t%0d", k), 32'(valid_o), 0);
      chk($sformatf("mul_start_t%0d", k), 32'(mdu_start_o), 0);
    end
    step();
    chk("mul_done_valid", 32'(valid_o), 1);
    chk("mul_done_code", 32'(ALUCtrl_o), 32'h8);
    chk("mul_done_ready", 32'(ready_o), 1);
    step();
    chk("held_add_valid", 32'(valid_o), 1);
    chk("held_add_code", 32'(ALUCtrl_o), 32'h2);
    drive(2'b00, 6'b0, 1'b0, 1'b0);
    step();

    // div then flush after T2
    drive(2'b10, 6'b011010, 1'b1, 1'b0);
    step();
    chk("div_start", 32'(mdu_start_o), 1);
    drive(2'b00, 6'b0, 1'b0, 1'b0);
    step();
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_ready", 32'(ready_o), 1);
    chk("flush_valid", 32'(valid_o), 0);
    chk("flush_mdu_op", 32'(mdu_op_o), 1);
    chk("flush_code_hold", 32'(ALUCtrl_o), 32'h2);
    for (int k = 0; k < MC; k++) begin
      step();
      chk("flush_no_late_valid", 32'(valid_o), 0);
    end

    // div then async reset mid-BUSY
    drive(2'b10, 6'b011010, 1'b1, 1'b0);
    step();
    drive(2'b00, 6'b0, 1'b0, 1'b0);
    step();
    chk("div2_busy", 32'(ready_o), 0);
    #2 rst_i = 1'b0;
    #1 chk_reset_vals("async_rst");
    #1 rst_i = 1'b1;
    drive(2'b00, 6'b0, 1'b1, 1'b0);
    step();
    chk("post_rst_add_valid", 32'(valid_o), 1);
    chk("post_rst_add_code", 32'(ALUCtrl_o), 32'h2);
    drive(2'b00, 6'b0, 1'b0, 1'b0);
    for (int k = 0; k < MC + 1; k++) begin
      step();
      chk("post_rst_no_valid", 32'(valid_o), 0);
    end
`else
    // Without the MDU, mult decodes as an illegal single-cycle op
    drive(2'b01, 6'b0, 1'b1, 1'b0);
    step();
    drive(2'b10, 6'b011000, 1'b1, 1'b0);
    step();
    chk("nomdu_mul_code", 32'(ALUCtrl_o), 32'h2);
    chk("nomdu_mul_illegal", 32'(illegal_o), 1);
    chk("nomdu_mul_valid", 32'(valid_o), 1);
    chk("nomdu_mul_ready", 32'(ready_o), 1);
    chk("nomdu_mul_start", 32'(mdu_start_o), 0);
    drive(2'b10, 6'b011010, 1'b1, 1'b0);
    step();
    chk("nomdu_div_illegal", 32'(illegal_o), 1);
    chk("nomdu_div_op", 32'(mdu_op_o), 0);
    drive(2'b00, 6'b0, 1'b0, 1'b0);
    step();
    #2 rst_i = 1'b0;
    #1 chk_reset_vals("async_rst");
    #1 rst_i = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
